// File: rtl/tsc_pkg.sv
// tsc_pkg: shared widths, default taps and FSM states
// for the TSC key decoder.
package tsc_pkg;

  localparam int LFSR_W  = 20;
  localparam int GROUPS  = 8;
  localparam int GROUP_W = 8;

  localparam logic [LFSR_W-1:0] LFSR_TAPS_DEF = 20'h90000;
  localparam logic [LFSR_W-1:0] SEED_ZERO     = 20'h00001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tsc_decoder_group_vote.sv
// group_vote: majority/tie of one 8-bit leaked group.
// Popcount >= 5 is a 1, <= 3 is a 0, exactly 4 is a tie.
module group_vote
  import tsc_pkg::*;
(
  input  logic [GROUP_W-1:0] grp,
  output logic               maj,
  output logic               tie
);

  logic [3:0] pc;

  // popcount of the group
  always_comb begin
    pc = '0;
    for (int i = 0; i < GROUP_W; i++) begin
      pc = pc + 4'(grp[i]);
    end
  end

  assign maj = (pc >= 4'd5);
  assign tie = (pc == 4'd4);

endmodule

// File: rtl/tsc_decoder.sv
// tsc_decoder: accumulates per-group votes over NUM_SAMPLES
// leaked samples, descrambled by a 20-bit Fibonacci LFSR.
module tsc_decoder
  import tsc_pkg::*;
#(
  parameter int unsigned       NUM_SAMPLES    = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY_TAPS = LFSR_TAPS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data,
  input  logic         sample_valid,
  output logic         sample_ready,
  input  logic [63:0]  load,
  output logic [7:0]   key_out,
  output logic [7:0]   key_tie,
  output logic [7:0]   erasures,
  output logic         done
);

  localparam int ACC_W = $clog2(NUM_SAMPLES) + 2;
  localparam logic [7:0] LAST = 8'(NUM_SAMPLES - 1);
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  state_e state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, seed;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ers_q, ers_d;
  logic [7:0] key_q, key_d;
  logic [7:0] tie_q, tie_d;
  logic       done_q, done_d;
  logic signed [ACC_W-1:0] acc_q [GROUPS];
  logic signed [ACC_W-1:0] acc_d [GROUPS];

  logic [GROUPS-1:0] maj, tie;
  logic [3:0] n_tie;
  logic [8:0] ers_sum;
  logic       unused_data;

  assign unused_data = ^data[127:LFSR_W];
  assign seed = (data[LFSR_W-1:0] == '0) ? SEED_ZERO
              : data[LFSR_W-1:0];

  for (genvar g = 0; g < GROUPS; g++) begin : g_vote
    group_vote u_vote (
      .grp (load[g*GROUP_W +: GROUP_W]),
      .maj (maj[g]),
      .tie (tie[g])
    );
  end

  // next-state: start wins, then sample accept, then DONE exit
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ers_d   = ers_q;
    key_d   = key_q;
    tie_d   = tie_q;
    done_d  = 1'b0;
    n_tie   = '0;
    for (int g = 0; g < GROUPS; g++) begin
      n_tie = n_tie + 4'(tie[g]);
    end
    ers_sum = {1'b0, ers_q} + 9'(n_tie);
    priority case (1'b1)
      start: begin
        state_d = RUN;
        lfsr_d  = seed;
        cnt_d   = '0;
        ers_d   = '0;
        for (int g = 0; g < GROUPS; g++) begin
          acc_d[g] = '0;
        end
      end
      (state_q == RUN) && sample_valid: begin
        for (int g = 0; g < GROUPS; g++) begin
          if (!tie[g]) begin
            if (maj[g] ^ lfsr_q[g]) begin
              acc_d[g] = acc_q[g] + ACC_ONE;
            end else begin
              acc_d[g] = acc_q[g] - ACC_ONE;
            end
          end
        end
        ers_d  = ers_sum[8] ? 8'hFF : ers_sum[7:0];
        lfsr_d = {lfsr_q[LFSR_W-2:0],
                  ^(lfsr_q & LFSR_POLY_TAPS)};
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == LAST) begin
          for (int g = 0; g < GROUPS; g++) begin
            key_d[g] = ~acc_d[g][ACC_W-1] & (|acc_d[g]);
            tie_d[g] = ~(|acc_d[g]);
          end
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      (state_q == DONE): state_d = IDLE;
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_ZERO;
      cnt_q   <= '0;
      ers_q   <= '0;
      key_q   <= '0;
      tie_q   <= '0;
      done_q  <= 1'b0;
      for (int g = 0; g < GROUPS; g++) begin
        acc_q[g] <= '0;
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ers_q   <= ers_d;
      key_q   <= key_d;
      tie_q   <= tie_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
    end
  end

  assign sample_ready = (state_q == RUN);
  assign key_out      = key_q;
  assign key_tie      = tie_q;
  assign erasures     = ers_q;
  assign done         = done_q;

endmodule

// File: tb/tb_tsc_decoder.sv
// tb_tsc_decoder: directed checks of tsc_decoder against
// a golden encoder model (LFSR scrambled, 3 flips per group).
module tb_tsc_decoder;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] data;
  logic         sample_valid;
  logic [63:0]  load;

  logic       sample_ready, done;
  logic [7:0] key_out, key_tie, erasures;
  logic       r1, d1;
  logic [7:0] k1, t1, e1;

  logic [19:0] m;
  int n_checks = 0;
  int n_fail   = 0;

  tsc_decoder u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data         (data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .load         (load),
    .key_out      (key_out),
    .key_tie      (key_tie),
    .erasures     (erasures),
    .done         (done)
  );

  tsc_decoder #(.NUM_SAMPLES(1)) u_one (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data         (data),
    .sample_valid (sample_valid),
    .sample_ready (r1),
    .load         (load),
    .key_out      (k1),
    .key_tie      (t1),
    .erasures     (e1),
    .done         (d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] lfsr_step(input logic [19:0] q);
    return {q[18:0], q[19] ^ q[16]};
  endfunction

  function automatic logic [7:0] rot3(input int r);
    logic [15:0] t;
    t = 16'h0007 << r;
    return t[7:0] | t[15:8];
  endfunction

  function automatic logic [63:0] enc(input logic [7:0] key,
                                      input logic [19:0] l,
                                      input int s);
    logic [63:0] v;
    for (int g = 0; g < 8; g++) begin
      v[g*8 +: 8] = {8{key[g] ^ l[g]}} ^ rot3((s + g) % 8);
    end
    return v;
  endfunction

  function automatic logic [7:0] tie_pat(input int i);
    case (i % 4)
      0:       return 8'h0F;
      1:       return 8'hF0;
      2:       return 8'h3C;
      default: return 8'h99;
    endcase
  endfunction

  task automatic begin_decode(input logic [127:0] d);
    data  = d;
    start = 1'b1;
    tick;
    start = 1'b0;
    m = (d[19:0] == 20'h0) ? 20'h00001 : d[19:0];
  endtask

  task automatic feed(input string tag, input logic [7:0] key,
                      input int n, input bit tie0,
                      input logic last_done);
    for (int i = 0; i < n; i++) begin
      logic [63:0] v;
      v = enc(key, m, i);
      if (tie0) v[7:0] = tie_pat(i);
      load = v;
      sample_valid = 1'b1;
      if (i == 0) chk({tag, "_ready"}, 64'(sample_ready), 64'd1);
      tick;
      m = lfsr_step(m);
      chk({tag, "_done"}, 64'(done),
          (i == n - 1) ? 64'(last_done) : 64'd0);
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    data = '0;
    sample_valid = 1'b0;
    load = '0;
    m = 20'h00001;
    #12;
    chk("rst_key", 64'(key_out), 64'h0);
    chk("rst_tie", 64'(key_tie), 64'h0);
    chk("rst_ers", 64'(erasures), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ready", 64'(sample_ready), 64'h0);
    chk("rst_ready1", 64'(r1), 64'h0);
    rst = 1'b1;
    tick;

    // single-sample decode of key A5
    begin_decode(128'h1);
    chk("one_ready", 64'(r1), 64'd1);
    load = 64'hFF00FF0000FF0000;
    sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
    chk("one_done", 64'(d1), 64'd1);
    chk("one_key", 64'(k1), 64'hA5);
    chk("one_tie", 64'(t1), 64'h0);
    chk("one_ers", 64'(e1), 64'h0);
    tick;
    chk("one_pulse", 64'(d1), 64'd0);
    chk("one_hold", 64'(k1), 64'hA5);

    // 16 noisy samples, key 3C
    begin_decode(128'hACE1);
    feed("k3c", 8'h3C, 16, 1'b0, 1'b1);
    chk("k3c_key", 64'(key_out), 64'h3C);
    chk("k3c_tie", 64'(key_tie), 64'h0);
    chk("k3c_ers", 64'(erasures), 64'h0);
    tick;
    chk("k3c_pulse", 64'(done), 64'd0);

    // group 0 always a tie, key C3
    begin_decode(128'h12345);
    feed("tie0", 8'hC3, 16, 1'b1, 1'b1);
    chk("tie0_key", 64'(key_out), 64'hC2);
    chk("tie0_tie", 64'(key_tie), 64'h01);
    chk("tie0_ers", 64'(erasures), 64'h10);
    tick;

    // restart at sample 7 with a valid sample present
    begin_decode(128'h0BEEF);
    feed("pre", 8'h5A, 7, 1'b0, 1'b0);
    data = 128'h54321;
    start = 1'b1;
    load = enc(8'h5A, m, 7);
    sample_valid = 1'b1;
    tick;
    start = 1'b0;
    m = 20'h54321;
    feed("rs", 8'h96, 16, 1'b0, 1'b1);
    chk("rs_key", 64'(key_out), 64'h96);
    chk("rs_ers", 64'(erasures), 64'h0);
    chk("rs_tie", 64'(key_tie), 64'h0);
    tick;

    // reset at sample 9
    begin_decode(128'h0F00D);
    feed("pr", 8'h77, 9, 1'b0, 1'b0);
    load = enc(8'h77, m, 9);
    sample_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_key", 64'(key_out), 64'h0);
    chk("ar_tie", 64'(key_tie), 64'h0);
    chk("ar_ers", 64'(erasures), 64'h0);
    chk("ar_done", 64'(done), 64'h0);
    chk("ar_ready", 64'(sample_ready), 64'h0);
    tick;
    chk("ar_done2", 64'(done), 64'h0);
    tick;
    rst = 1'b1;
    tick;
    chk("ar_wait", 64'(sample_ready), 64'h0);
    chk("ar_wait_done", 64'(done), 64'h0);
    begin_decode(128'h0F00D);
    feed("fr", 8'h77, 16, 1'b0, 1'b1);
    chk("fr_key", 64'(key_out), 64'h77);
    chk("fr_ers", 64'(erasures), 64'h0);

    // valid held through DONE and IDLE, then zero seed
    sample_valid = 1'b1;
    load = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("dn_ready", 64'(sample_ready), 64'h0);
    tick;
    chk("id_done", 64'(done), 64'h0);
    chk("id_ready", 64'(sample_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("id_hold_key", 64'(key_out), 64'h77);
      chk("id_hold_ers", 64'(erasures), 64'h0);
      chk("id_hold_done", 64'(done), 64'h0);
    end
    begin_decode({108'hDEAD_BEEF, 20'h0});
    feed("z0", 8'hE1, 1, 1'b0, 1'b0);
    chk("z0_one_done", 64'(d1), 64'd1);
    chk("z0_one_key", 64'(k1), 64'hE1);
    feed("z1", 8'hE1, 15, 1'b0, 1'b1);
    chk("z_key", 64'(key_out), 64'hE1);
    chk("z_ers", 64'(erasures), 64'h0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tsc_decoder.md
TSC_DECODER -- requirements
Module: tsc_decoder

Interface
REQ-001 Parameter NUM_SAMPLES, default 16, gives the number of accepted load samples per decode; legal range is 1..255.
REQ-002 Parameter LFSR_POLY_TAPS, default 20'h90000, gives the feedback taps (bits 19 and 16) of the 20-bit Fibonacci LFSR.
REQ-003 clk  input  1  is the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  is the asynchronous, active-low reset.
REQ-005 start  input  1  is a one-cycle request that begins a decode, seeding the LFSR and clearing the accumulators.
REQ-006 data  input  128  is the seed source; only data[19:0] is used.
REQ-007 sample_valid  input  1  indicates that load holds a sample.
REQ-008 sample_ready  output  1  is high exactly while in state RUN.
REQ-009 load  input  64  is the leaked vector; group g (0..7) is load[8g+7:8g].
REQ-010 key_out  output  8  is the recovered key[7:0].
REQ-011 key_tie  output  8  flags key bits whose vote ended at zero.
REQ-012 erasures  output  8  is the count of group-level ties, saturating at 255.
REQ-013 done  output  1  is a one-cycle pulse indicating that key_out, key_tie and erasures are final.

Function
REQ-014 The FSM states SHALL be IDLE, RUN and DONE; DONE lasts one cycle and then returns to IDLE.
REQ-015 On start in any state, the block SHALL load the LFSR with data[19:0] (20'h00001 if zero), clear the accumulators, erasures and the sample counter, and enter RUN.
REQ-016 A sample SHALL be accepted when sample_valid and sample_ready are both high and start is low; start takes priority, so a sample presented in the same cycle as start is dropped.
REQ-017 Per accepted sample and per group g, the majority SHALL be 1 if popcount ≥ 5, 0 if popcount ≤ 3, and a tie if popcount = 4.
REQ-018 For a non-tie group, the bit estimate SHALL be majority XOR lfsr[g] using the LFSR value before its advance; a estimate of 1 adds +1 to the signed accumulator acc[g] and a estimate of 0 adds −1.
REQ-019 For a tie, acc[g] SHALL remain unchanged and erasures SHALL increment by 1, saturating.
REQ-020 The LFSR SHALL advance exactly once per accepted sample: next = {q[18:0], ^(q & LFSR_POLY_TAPS)}.
REQ-021 The accumulators SHALL be signed, clog2(NUM_SAMPLES)+2 bits wide, and SHALL never overflow.
REQ-022 After the NUM_SAMPLES-th accepted sample, the next cycle SHALL register key_out[g] = (acc[g] > 0) and key_tie[g] = (acc[g] == 0), assert done, and enter DONE.
REQ-023 The done-to-last-accept latency SHALL be exactly 1 cycle.
REQ-024 key_out, key_tie and erasures SHALL hold their values until the next start or reset.
REQ-025 Samples presented in IDLE or DONE SHALL be ignored; sample_ready is low in both states.

Reset
REQ-026 While rst is low, the block SHALL be in state IDLE with key_out = 0, key_tie = 0, erasures = 0, done = 0, sample_ready = 0, LFSR = 20'h00001 and all accumulators = 0.
REQ-027 A reset asserted mid-RUN SHALL abandon the decode immediately with no done pulse; after release the block waits for start.

Structure
REQ-028 A shared package tsc_pkg SHALL hold LFSR_W=20, GROUPS=8, GROUP_W=8, the default taps, the seed-zero substitute, and the state enumeration.
REQ-029 The group majority SHALL be a sub-module, group_vote (8-bit in, maj/tie out), instantiated 8 times.
REQ-030 The LFSR SHALL be inline, matching the transmitter-side counter step for step.

Verification
REQ-031 Reset, then apply start with data[19:0]=20'h00001 and sample load=64'hFF00FF0000FF0000 (the key byte 8'hA5 encoded) -> with NUM_SAMPLES=1, done one cycle later, key_out=8'hA5, key_tie=0, erasures=0.
REQ-032 Feed 16 samples of a golden encoder model with key byte 8'h3C, flipping 3 bits per group in every sample -> key_out=8'h3C, erasures=0.
REQ-033 Feed 16 samples with group 0 fixed at popcount 4 -> erasures=16, key_tie[0]=1, key_out[0]=0.
REQ-034 Assert start at sample 7 of a decode, together with sample_valid high -> that sample is dropped, the counter restarts, and exactly 16 further samples are needed before done.
REQ-035 Pull rst low at sample 9 -> all outputs zero asynchronously, no done pulse; a fresh start then decodes correctly.
REQ-036 Hold sample_valid high across IDLE and DONE, and apply start with data[19:0]=0 -> nothing is accepted outside RUN, and the LFSR seeds to 20'h00001.
